// File: rtl/frame_decoder.sv
// Byte-stuffed frame decoder: strips SOF/EOF/ESC markers from a raw byte stream
// and emits decoded frame bytes with tlast, using a one-byte hold and one output stage.
`timescale 1ns/1ps
module frame_decoder #(
    parameter logic [7:0] SOF_BYTE = 8'h7E,
    parameter logic [7:0] EOF_BYTE = 8'h7F,
    parameter logic [7:0] ESC_BYTE = 8'h7D
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       target_tvalid,
    output logic       target_tready,
    input  logic [7:0] target_tdata,
    output logic       initiator_tvalid,
    input  logic       initiator_tready,
    output logic       initiator_tlast,
    output logic [7:0] initiator_tdata,
    output logic       frame_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        ESCAPE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] hold_data;
    logic       hold_full;

    logic       accept;
    logic       is_sof;
    logic       is_eof;
    logic       is_esc;
    logic [7:0] data_byte;
    logic       emit;
    logic       emit_last;
    logic       load_hold;
    logic       clear_hold;
    logic       abort;

    // Input may only be taken when the output stage is free or draining this cycle.
    assign target_tready = !initiator_tvalid || initiator_tready;
    assign accept        = target_tvalid && target_tready;
    assign is_sof        = (target_tdata == SOF_BYTE);
    assign is_eof        = (target_tdata == EOF_BYTE);
    assign is_esc        = (target_tdata == ESC_BYTE);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (is_sof) state_next = DATA;
                end
                DATA: begin
                    if (is_sof)      state_next = DATA;
                    else if (is_eof) state_next = IDLE;
                    else if (is_esc) state_next = ESCAPE;
                end
                ESCAPE: begin
                    if (is_eof) state_next = IDLE;
                    else        state_next = DATA;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        emit       = 1'b0;
        emit_last  = 1'b0;
        load_hold  = 1'b0;
        clear_hold = 1'b0;
        abort      = 1'b0;
        data_byte  = (state == ESCAPE) ? (target_tdata ^ 8'h20) : target_tdata;
        if (accept) begin
            case (state)
                IDLE: begin
                    clear_hold = is_sof;
                end
                DATA: begin
                    if (is_sof) begin
                        emit       = hold_full;
                        emit_last  = 1'b1;
                        clear_hold = 1'b1;
                        abort      = 1'b1;
                    end else if (is_eof) begin
                        emit       = hold_full;
                        emit_last  = 1'b1;
                        clear_hold = 1'b1;
                    end else if (!is_esc) begin
                        emit      = hold_full;
                        load_hold = 1'b1;
                    end
                end
                ESCAPE: begin
                    if (is_sof || is_eof) begin
                        emit       = hold_full;
                        emit_last  = 1'b1;
                        clear_hold = 1'b1;
                        abort      = 1'b1;
                    end else begin
                        emit      = hold_full;
                        load_hold = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The held byte is only released once we know whether it closes the frame.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hold_data        <= 8'h00;
            hold_full        <= 1'b0;
            initiator_tvalid <= 1'b0;
            initiator_tlast  <= 1'b0;
            initiator_tdata  <= 8'h00;
            frame_error      <= 1'b0;
        end else begin
            frame_error <= abort;
            if (load_hold) begin
                hold_data <= data_byte;
                hold_full <= 1'b1;
            end else if (clear_hold) begin
                hold_full <= 1'b0;
            end
            if (emit) begin
                initiator_tvalid <= 1'b1;
                initiator_tdata  <= hold_data;
                initiator_tlast  <= emit_last;
            end else if (initiator_tready) begin
                initiator_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_decoder.sv
// Self-checking bench for frame_decoder: a frame-level reference decoder predicts
// beats and abort counts; one compare process checks every output handshake.
`timescale 1ns/1ps
module tb_frame_decoder;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    localparam logic [7:0] SOF = 8'h7E;
    localparam logic [7:0] EOF = 8'h7F;
    localparam logic [7:0] ESC = 8'h7D;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       target_tvalid = 1'b0;
    logic       target_tready;
    logic [7:0] target_tdata = 8'h00;
    logic       initiator_tvalid;
    logic       initiator_tready = 1'b1;
    logic       initiator_tlast;
    logic [7:0] initiator_tdata;
    logic       frame_error;

    int    total = 0;
    int    bad = 0;
    int    err_seen = 0;
    bit    rand_ready = 1'b0;
    beat_t exp_q[$];
    beat_t exp_b;
    logic       prev_stall = 1'b0;
    logic       prev_err = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       prev_l = 1'b0;

    always #5 aclk = ~aclk;

    frame_decoder dut (
        .aclk             (aclk),
        .areset           (areset),
        .target_tvalid    (target_tvalid),
        .target_tready    (target_tready),
        .target_tdata     (target_tdata),
        .initiator_tvalid (initiator_tvalid),
        .initiator_tready (initiator_tready),
        .initiator_tlast  (initiator_tlast),
        .initiator_tdata  (initiator_tdata),
        .frame_error      (frame_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: whole frames are collected, then released with tlast on the final byte.
    function automatic void model(input bq_t s, output int errs);
        bq_t cur;
        bit  in_frame = 1'b0;
        bit  escaped = 1'b0;
        errs = 0;
        foreach (s[k]) begin
            if (!in_frame) begin
                if (s[k] == SOF) begin
                    in_frame = 1'b1;
                    escaped  = 1'b0;
                    cur.delete();
                end
            end else if (s[k] == SOF || s[k] == EOF) begin
                if (s[k] == SOF || escaped) errs++;
                for (int i = 0; i < cur.size(); i++)
                    exp_q.push_back(beat_t'{d: cur[i], l: (i == cur.size() - 1)});
                cur.delete();
                escaped  = 1'b0;
                in_frame = (s[k] == SOF);
            end else if (escaped) begin
                cur.push_back(s[k] ^ 8'h20);
                escaped = 1'b0;
            end else if (s[k] == ESC) begin
                escaped = 1'b1;
            end else begin
                cur.push_back(s[k]);
            end
        end
    endfunction

    always @(negedge aclk) begin
        if (rand_ready) initiator_tready = 1'($urandom_range(0, 1));
    end

    always @(negedge aclk) begin
        #2;
        if (areset) begin
            prev_stall = 1'b0;
            prev_err   = 1'b0;
        end else begin
            check("tready_rule", 32'(target_tready), 32'(!initiator_tvalid || initiator_tready));
            if (prev_stall) begin
                check("stall_valid", 32'(initiator_tvalid), 32'd1);
                check("stall_data", 32'(initiator_tdata), 32'(prev_d));
                check("stall_last", 32'(initiator_tlast), 32'(prev_l));
            end
            if (frame_error) begin
                err_seen++;
                check("err_width", 32'(prev_err), 32'd0);
            end
            prev_err = frame_error;
            if (initiator_tvalid && initiator_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got data %0h last %0b want no beat",
                             initiator_tdata, initiator_tlast);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat_data", 32'(initiator_tdata), 32'(exp_b.d));
                    check("beat_last", 32'(initiator_tlast), 32'(exp_b.l));
                end
            end
            prev_stall = initiator_tvalid && !initiator_tready;
            prev_d     = initiator_tdata;
            prev_l     = initiator_tlast;
        end
    end

    task automatic send(input string name, input bq_t s);
        bit done;
        foreach (s[k]) begin
            @(negedge aclk);
            target_tvalid = 1'b1;
            target_tdata  = s[k];
            done = 1'b0;
            for (int n = 0; n < 200 && !done; n++) begin
                #1;
                if (target_tready) done = 1'b1;
                @(posedge aclk);
                if (!done) @(negedge aclk);
            end
            if (!done) check({name, "_accept_timeout"}, 32'd0, 32'd1);
        end
        @(negedge aclk);
        target_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge aclk);
            n++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge aclk);
    endtask

    // Hand-computed beat count, final byte and abort count pin the reference model.
    task automatic run(input string name, input bq_t s, input int exp_errs,
                       input int exp_n, input logic [7:0] exp_last_d);
        int errs;
        err_seen = 0;
        model(s, errs);
        check({name, "_model_errs"}, 32'(errs), 32'(exp_errs));
        check({name, "_model_beats"}, 32'(exp_q.size()), 32'(exp_n));
        if (exp_q.size() > 0) begin
            check({name, "_model_last_d"}, 32'(exp_q[exp_q.size() - 1].d), 32'(exp_last_d));
            check({name, "_model_last_l"}, 32'(exp_q[exp_q.size() - 1].l), 32'd1);
        end
        send(name, s);
        drain(name);
        check({name, "_frame_error"}, 32'(err_seen), 32'(errs));
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_tvalid"}, 32'(initiator_tvalid), 32'd0);
        check({name, "_tlast"}, 32'(initiator_tlast), 32'd0);
        check({name, "_tdata"}, 32'(initiator_tdata), 32'd0);
        check({name, "_ferr"}, 32'(frame_error), 32'd0);
        check({name, "_tready"}, 32'(target_tready), 32'd1);
    endtask

    initial begin
        bq_t s;
        repeat (3) @(negedge aclk);
        #2;
        check_reset_values("rst0");
        @(negedge aclk);
        areset = 1'b0;

        s = {8'h7E, 8'h01, 8'h02, 8'h03, 8'h7F};
        run("t_basic", s, 0, 3, 8'h03);
        s = {8'h7E, 8'h7D, 8'h5E, 8'h7D, 8'h5D, 8'h7F};
        run("t_escape", s, 0, 2, 8'h7D);
        s = {8'hAA, 8'h7E, 8'h7F, 8'h7E, 8'h11, 8'h7F};
        run("t_garbage", s, 0, 1, 8'h11);
        s = {8'h7E, 8'h01, 8'h02, 8'h7E, 8'h05, 8'h7F};
        run("t_sof_abort", s, 1, 3, 8'h05);
        s = {8'h7E, 8'h01, 8'h7D, 8'h7F, 8'h7E, 8'h7D, 8'h7D, 8'h7F};
        run("t_esc_abort", s, 1, 2, 8'h5D);

        s.delete();
        s.push_back(8'h7E);
        for (int i = 1; i <= 16; i++) s.push_back(8'(i));
        s.push_back(8'h7F);
        rand_ready = 1'b1;
        run("t_stall", s, 0, 16, 8'h10);
        rand_ready = 1'b0;
        @(negedge aclk);
        initiator_tready = 1'b1;
        repeat (3) @(negedge aclk);

        initiator_tready = 1'b0;
        s = {8'h7E, 8'h01, 8'h02};
        send("t_rst_pre", s);
        #2;
        check("t_rst_pending", 32'(initiator_tvalid), 32'd1);
        areset = 1'b1;
        @(negedge aclk);
        #2;
        check_reset_values("rst_mid");
        @(negedge aclk);
        areset = 1'b0;
        initiator_tready = 1'b1;
        s = {8'h7E, 8'h09, 8'h7F};
        run("t_after_rst", s, 0, 1, 8'h09);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
